idct_transpose: RTL and testbench
=================================

# idct_transpose

Ping-pong transpose buffer between the row IDCT stage and the column IDCT stage of the 2-D inverse transform. It collects one 4x4 or 8x8 block of row-stage results arriving in raster (row-major) order and replays it in column-major order as a continuous sample stream. The stream carries a block-size code in the same 2-bit format the column stage takes on its idct4 input. Two banks let a new block be written while the previous one is read out.

## Interface
- WIDTH_X, 16, sample width in bits (signed two's complement)
- clk  input  1  rising-edge clock, only clock of the block
- rst_n  input  1  asynchronous reset, active-high (asserted when 1)
- in_valid  input  1  in_data holds a row-stage sample this cycle
- in_size  input  1  block size, 0 = 4x4, 1 = 8x8; sampled only on the first sample of a block
- in_data  input  WIDTH_X  signed row-stage sample, raster order
- out_valid  output  1  out_data valid
- out_data  output  WIDTH_X  signed sample, column-major order
- out_mode  output  2  2'b01 = 4x4 block, 2'b10 = 8x8 block, 2'b00 when out_valid = 0
- out_first  output  1  pulse on the first sample of an output block
- out_last  output  1  pulse on the last sample of an output block
- err  output  1  sticky overrun flag, cleared only by reset

## Operation
- Storage: two banks A/B, 64 x WIDTH_X each, addressed r*8+c (r = row, c = column, 0..N-1, N = 4 or 8). Array contents are not reset.
- Each bank has a state: EMPTY, FILLING, FULL, READING.
- Write side:
  - Write pointer selects the target bank; A after reset.
  - On in_valid with write counter = 0, latch in_size into the target bank's size and move the bank EMPTY -> FILLING.
  - Each in_valid writes buf[r][c] and advances c, then r, for N*N samples. Gaps in in_valid are allowed; counters hold.
  - On the N*N-th sample, the bank moves FILLING -> FULL, the write counter clears, and the write pointer toggles.
- Overrun:
  - If the target bank is not EMPTY when a block's first sample arrives, the whole block (N*N samples at the latched size) is counted but not written.
  - err is set on that first sample and the bank states are left untouched.
- Read side:
  - The read pointer starts at A and always serves banks in fill order.
  - When the read-pointer bank is FULL and the reader is idle, the bank moves to READING. The read index then steps k = 0..N*N-1, one per cycle without stalls, emitting buf[k mod N][k div N].
  - After index N*N-1, the bank returns to EMPTY and the read pointer toggles.
  - If the other bank is already FULL, its read starts on the next cycle with no gap.
- Simultaneous events: a bank leaving READING -> EMPTY on the same edge that the write side targets it with a block's first sample counts as EMPTY, so no overrun occurs.
- Arithmetic: none; samples pass bit-exact, sign preserved.

## Timing
- All outputs are registered.
- Reset values: out_valid = 0, out_data = 0, out_mode = 2'b00, out_first = 0, out_last = 0, err = 0. Both banks EMPTY, both pointers at A, all counters 0.
- Latency: if the last sample of a block is written at edge E and the reader is idle, out_valid = 1 from edge E+1 through edge E+N*N.
  - out_first is high at E+1.
  - out_last is high at E+N*N.
- Back-to-back equal-size blocks produce an unbroken out_valid stream.
- out_mode is constant across a block and is taken from the size latched for that bank.
- Reset asserted mid-operation, including mid-fill and mid-read, immediately discards all blocks and forces the reset values. The first in_valid after release starts a new block in bank A.

## Test plan
- Single 8x8 block, in_data = r*8+c, in_valid continuous:
  - out_data = 0, 8, 16, ..., 56, 1, 9, ..., 63.
  - out_valid asserts 1 cycle after the last input, out_mode = 2'b10.
  - out_first on value 0, out_last on value 63.
- Single 4x4 block, in_data = r*4+c, with one idle cycle inserted after every third sample:
  - out_data = 0, 4, 8, 12, 1, 5, ..., 15 in 16 consecutive cycles, out_mode = 2'b01.
- Three back-to-back 8x8 blocks with continuous input:
  - 192 consecutive out_valid cycles, each block transposed, out_first/out_last at 64-sample boundaries, err = 0.
- 8x8, then 4x4, then 4x4, all back to back:
  - First 4x4 is read immediately after the 8x8 (no gap).
  - Third block targets bank A while A is READING; it is dropped and err = 1.
  - Output is 80 samples total, with err staying 1 afterwards.
- Sign extremes: in_data alternating -32768 / 32767 in an 8x8 block -> values reappear bit-exact at transposed positions.
- Reset pulse at read index 20 of an 8x8 block:
  - All outputs read 0 from the reset edge and no remaining samples are emitted.
  - A following 4x4 block is transposed correctly from bank A.

Source files
------------

// File: rtl/idct_transpose.sv
// idct_transpose: ping-pong buffer turning raster-order 4x4/8x8 row-stage blocks
// into a column-major sample stream for the column IDCT stage.
module idct_transpose #(
    parameter int WIDTH_X = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic                      in_size,
    input  logic signed [WIDTH_X-1:0] in_data,
    output logic                      out_valid,
    output logic signed [WIDTH_X-1:0] out_data,
    output logic [1:0]                out_mode,
    output logic                      out_first,
    output logic                      out_last,
    output logic                      err
);
    localparam logic [1:0] EMPTY   = 2'd0;
    localparam logic [1:0] FILLING = 2'd1;
    localparam logic [1:0] FULL    = 2'd2;
    localparam logic [1:0] READING = 2'd3;
    logic [WIDTH_X-1:0] mem [128];
    logic [1:0] st [2];
    logic [1:0] bank_size;
    logic       wr_ptr, wr_size, wr_drop;
    logic [5:0] wr_cnt;
    logic       rd_ptr, rd_busy;
    logic [5:0] rd_idx;
    logic       wr_first, wr_sz, wr_last, wr_free, wr_skip, wr_en;
    logic [5:0] wr_addr;
    logic       rd_sz, rd_emit, rd_done;
    logic [5:0] rd_k, rd_end, rd_addr;
    always_comb begin
        wr_first = wr_cnt == 6'd0;
        wr_sz    = wr_first ? in_size : wr_size;
        wr_last  = wr_cnt == (wr_sz ? 6'd63 : 6'd15);
        wr_addr  = wr_sz ? wr_cnt : {1'b0, wr_cnt[3:2], 1'b0, wr_cnt[1:0]};
        rd_sz    = bank_size[rd_ptr];
        rd_end   = rd_sz ? 6'd63 : 6'd15;
        rd_emit  = rd_busy || st[rd_ptr] == FULL;
        rd_k     = rd_busy ? rd_idx : 6'd0;
        rd_done  = rd_busy && rd_idx == rd_end;
        rd_addr  = rd_sz ? {rd_k[2:0], rd_k[5:3]} : {1'b0, rd_k[1:0], 1'b0, rd_k[3:2]};
        // a bank finishing its readout on this edge is already free for a new block
        wr_free  = st[wr_ptr] == EMPTY || (rd_done && rd_ptr == wr_ptr);
        wr_skip  = wr_first ? !wr_free : wr_drop;
        wr_en    = in_valid && !wr_skip;
    end
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[{wr_ptr, wr_addr}] <= in_data;
    end
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_mode  <= 2'b00;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            err       <= 1'b0;
            st[0]     <= EMPTY;
            st[1]     <= EMPTY;
            bank_size <= 2'b00;
            wr_ptr    <= 1'b0;
            wr_size   <= 1'b0;
            wr_drop   <= 1'b0;
            wr_cnt    <= 6'd0;
            rd_ptr    <= 1'b0;
            rd_busy   <= 1'b0;
            rd_idx    <= 6'd0;
        end else begin
            out_valid <= rd_emit;
            out_data  <= rd_emit ? mem[{rd_ptr, rd_addr}] : '0;
            out_mode  <= rd_emit ? (rd_sz ? 2'b10 : 2'b01) : 2'b00;
            out_first <= rd_emit && rd_k == 6'd0;
            out_last  <= rd_done;
            if (rd_emit) begin
                if (rd_done) begin
                    rd_busy    <= 1'b0;
                    rd_idx     <= 6'd0;
                    rd_ptr     <= ~rd_ptr;
                    st[rd_ptr] <= EMPTY;
                end else begin
                    rd_busy    <= 1'b1;
                    rd_idx     <= rd_k + 6'd1;
                    st[rd_ptr] <= READING;
                end
            end
            // write-side updates come last so a refill of a just-freed bank wins
            if (in_valid) begin
                if (wr_first) begin
                    wr_size <= in_size;
                    wr_drop <= !wr_free;
                    if (!wr_free)
                        err <= 1'b1;
                end
                if (wr_en && wr_first) begin
                    st[wr_ptr]        <= FILLING;
                    bank_size[wr_ptr] <= in_size;
                end
                if (wr_last) begin
                    wr_cnt <= 6'd0;
                    if (wr_en) begin
                        st[wr_ptr] <= FULL;
                        wr_ptr     <= ~wr_ptr;
                    end
                end else begin
                    wr_cnt <= wr_cnt + 6'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_idct_transpose.sv
// tb_idct_transpose: directed/random blocks checked against a matrix-transpose model.
module tb_idct_transpose;
    logic clk = 1'b0;
    logic rst_n, in_valid, in_size;
    logic signed [15:0] in_data;
    logic out_valid, out_first, out_last, err;
    logic signed [15:0] out_data;
    logic [1:0] out_mode;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    typedef struct {
        logic [15:0] d;
        logic [1:0]  m;
        logic        f;
        logic        l;
        int          cyc;
    } smp_t;
    smp_t obs_q[$];
    smp_t exp_q[$];
    idct_transpose #(.WIDTH_X(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_size(in_size), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .out_mode(out_mode),
        .out_first(out_first), .out_last(out_last), .err(err)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc++;
        #1;
        if (out_valid)
            obs_q.push_back('{out_data, out_mode, out_first, out_last, cyc});
    end
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask
    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_data"}, 32'(out_data), 0);
        chk({tag, "_mode"}, 32'(out_mode), 0);
        chk({tag, "_first"}, 32'(out_first), 0);
        chk({tag, "_last"}, 32'(out_last), 0);
    endtask
    // kind: 0 = r*N+c, 1 = random, 2 = alternating sign extremes; keep = expected outputs to model
    task automatic send(input bit sz, input int kind, input bit gaps, input int keep, output int last_e);
        int n;
        logic [15:0] m [8][8];
        n = sz ? 8 : 4;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                if (kind == 0) m[r][c] = 16'(r * n + c);
                else if (kind == 1) m[r][c] = 16'($urandom);
                else m[r][c] = ((r * n + c) % 2 == 1) ? 16'h7fff : 16'h8000;
            end
        last_e = 0;
        for (int k = 0; k < n * n; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_size  = (k == 0) ? sz : 1'($urandom);
            in_data  = m[k / n][k % n];
            last_e   = cyc + 1;
            if (gaps && k % 3 == 2) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
        end
        for (int i = 0; i < n * n && i < keep; i++)
            exp_q.push_back('{m[i % n][i / n], sz ? 2'b10 : 2'b01, i == 0, i == n * n - 1, 0});
    endtask
    task automatic drain(input string tag, input bit contig, input int first_cyc);
        int n;
        @(negedge clk);
        in_valid = 1'b0;
        for (int t = 0; t < 400 && obs_q.size() < exp_q.size(); t++)
            @(negedge clk);
        repeat (5) @(negedge clk);
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        n = obs_q.size() < exp_q.size() ? obs_q.size() : exp_q.size();
        if (first_cyc >= 0 && n > 0)
            chk({tag, "_latency"}, obs_q[0].cyc, first_cyc);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_data[%0d]", tag, i), 32'(obs_q[i].d), 32'(exp_q[i].d));
            chk($sformatf("%s_mode[%0d]", tag, i), 32'(obs_q[i].m), 32'(exp_q[i].m));
            chk($sformatf("%s_first[%0d]", tag, i), 32'(obs_q[i].f), 32'(exp_q[i].f));
            chk($sformatf("%s_last[%0d]", tag, i), 32'(obs_q[i].l), 32'(exp_q[i].l));
            if (contig && i > 0)
                chk($sformatf("%s_gap[%0d]", tag, i), obs_q[i].cyc - obs_q[i - 1].cyc, 1);
        end
        chk_idle({tag, "_after"});
        obs_q.delete();
        exp_q.delete();
    endtask
    initial begin
        int e;
        rst_n = 1'b1;
        in_valid = 1'b0;
        in_size = 1'b0;
        in_data = '0;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        chk("reset_err", 32'(err), 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        send(1'b1, 0, 1'b0, 64, e);
        drain("ramp8", 1'b1, e + 1);
        send(1'b0, 0, 1'b1, 16, e);
        drain("ramp4_gaps", 1'b1, e + 1);
        send(1'b1, 1, 1'b0, 64, e);
        send(1'b1, 1, 1'b0, 64, e);
        send(1'b1, 1, 1'b0, 64, e);
        drain("three8", 1'b1, -1);
        chk("three8_err", 32'(err), 0);
        send(1'b1, 1, 1'b0, 64, e);
        send(1'b0, 1, 1'b0, 16, e);
        send(1'b0, 1, 1'b0, 0, e);
        drain("overrun", 1'b1, -1);
        chk("overrun_err", 32'(err), 1);
        repeat (10) @(negedge clk);
        chk("overrun_err_sticky", 32'(err), 1);
        send(1'b1, 2, 1'b0, 64, e);
        drain("extremes", 1'b1, e + 1);
        send(1'b1, 1, 1'b0, 20, e);
        @(negedge clk);
        in_valid = 1'b0;
        for (int t = 0; t < 200 && obs_q.size() < 20; t++)
            @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_idle("midreset");
        chk("midreset_err", 32'(err), 0);
        @(negedge clk);
        rst_n = 1'b0;
        drain("midreset_stream", 1'b1, -1);
        send(1'b0, 0, 1'b0, 16, e);
        drain("post_reset4", 1'b1, e + 1);
        chk("final_err", 32'(err), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
